// File: rtl/add_pipe_pkg.sv
// Shared constants and chunk-geometry helpers for the pipelined adder.
package add_pipe_pkg;

  localparam int DEFAULT_DATAWIDTH = 32;
  localparam int DEFAULT_STAGES    = 4;

  function automatic int chunk_width(input int dw, input int st);
    return (dw + st - 1) / st;
  endfunction

  function automatic int chunk_lo(input int dw, input int st, input int k);
    return k * chunk_width(dw, st);
  endfunction

  // Last chunk is clipped to the operand width.
  function automatic int chunk_hi(input int dw, input int st, input int k);
    int top;
    top = (k + 1) * chunk_width(dw, st);
    if (top > dw) top = dw;
    return top - 1;
  endfunction

  function automatic bit chunk_active(input int dw, input int st, input int k);
    return chunk_lo(dw, st, k) < dw;
  endfunction

  // Trailing empty chunks report a 1-bit width so their ports stay legal.
  function automatic int chunk_bits(input int dw, input int st, input int k);
    return chunk_active(dw, st, k) ? (chunk_hi(dw, st, k) - chunk_lo(dw, st, k) + 1) : 1;
  endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result bus of add_pipe. The stall line exists only when
// ADD_PIPE_STALL_EN is defined.
interface add_pipe_if
  import add_pipe_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
);
  logic                 valid_in;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 ci;
  logic                 valid_out;
  logic [DATAWIDTH-1:0] sum;
  logic                 co;

`ifdef ADD_PIPE_STALL_EN
  logic                 stall;

  modport master (output valid_in, a, b, ci, stall, input valid_out, sum, co);
  modport slave  (input valid_in, a, b, ci, stall, output valid_out, sum, co);
`else
  modport master (output valid_in, a, b, ci, input valid_out, sum, co);
  modport slave  (input valid_in, a, b, ci, output valid_out, sum, co);
`endif
endinterface

// File: rtl/add_pipe_stage.sv
// One carry chunk of add_pipe: operand skew line, registered chunk adder,
// and result deskew line. Empty trailing chunks only forward the carry.
module add_pipe_stage
  import add_pipe_pkg::*;
#(
  parameter  int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter  int STAGES    = DEFAULT_STAGES,
  parameter  int IDX       = 0,
  localparam int W         = chunk_bits(DATAWIDTH, STAGES, IDX)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_adv,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_sum,
  output logic         o_co
);
  localparam bit ACTIVE = chunk_active(DATAWIDTH, STAGES, IDX);
  localparam int DESKEW = STAGES - 1 - IDX;
  localparam int WP     = W + 1;

  logic r_co;
  assign o_co = r_co;

  if (ACTIVE) begin : g_active
    logic [W-1:0] w_a_sk;
    logic [W-1:0] w_b_sk;
    logic [W:0]   w_add;
    logic [W-1:0] r_sum;

    if (IDX == 0) begin : g_noskew
      assign w_a_sk = i_a;
      assign w_b_sk = i_b;
    end else begin : g_skew
      logic [W-1:0] r_a [IDX];
      logic [W-1:0] r_b [IDX];
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < IDX; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
          end
        end else if (i_adv) begin
          r_a[0] <= i_a;
          r_b[0] <= i_b;
          for (int i = 1; i < IDX; i++) begin
            r_a[i] <= r_a[i-1];
            r_b[i] <= r_b[i-1];
          end
        end
      end
      assign w_a_sk = r_a[IDX-1];
      assign w_b_sk = r_b[IDX-1];
    end

    assign w_add = {1'b0, w_a_sk} + {1'b0, w_b_sk} + WP'(i_ci);

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sum <= '0;
        r_co  <= 1'b0;
      end else if (i_adv) begin
        r_sum <= w_add[W-1:0];
        r_co  <= w_add[W];
      end
    end

    if (DESKEW == 0) begin : g_nodeskew
      assign o_sum = r_sum;
    end else begin : g_deskew
      logic [W-1:0] r_d [DESKEW];
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DESKEW; i++) r_d[i] <= '0;
        end else if (i_adv) begin
          r_d[0] <= r_sum;
          for (int i = 1; i < DESKEW; i++) r_d[i] <= r_d[i-1];
        end
      end
      assign o_sum = r_d[DESKEW-1];
    end
  end else begin : g_empty
    always_ff @(posedge i_clk) begin
      if (i_rst)      r_co <= 1'b0;
      else if (i_adv) r_co <= i_ci;
    end
    assign o_sum = '0;
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined DATAWIDTH adder split into STAGES carry chunks, latency STAGES.
// Define ADD_PIPE_STALL_EN to add a pipeline-wide stall on the bus.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int STAGES    = DEFAULT_STAGES
) (
  input  logic      clk,
  input  logic      rst,
  add_pipe_if.slave bus
);
  logic                 w_adv;
  logic [STAGES:0]      w_carry;
  logic [DATAWIDTH-1:0] w_sum;
  logic [STAGES-1:0]    r_valid;

`ifdef ADD_PIPE_STALL_EN
  assign w_adv = ~bus.stall;
`else
  assign w_adv = 1'b1;
`endif

  assign w_carry[0] = bus.ci;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid[0] <= bus.valid_in;
      for (int i = 1; i < STAGES; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = chunk_lo(DATAWIDTH, STAGES, k);
    localparam int HI  = chunk_hi(DATAWIDTH, STAGES, k);
    localparam int W   = chunk_bits(DATAWIDTH, STAGES, k);
    localparam bit ACT = chunk_active(DATAWIDTH, STAGES, k);

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_s;

    if (ACT) begin : g_slice
      assign w_a          = bus.a[HI:LO];
      assign w_b          = bus.b[HI:LO];
      assign w_sum[HI:LO] = w_s;
    end else begin : g_pad
      assign w_a = '0;
      assign w_b = '0;
    end

    add_pipe_stage #(
      .DATAWIDTH (DATAWIDTH),
      .STAGES    (STAGES),
      .IDX       (k)
    ) u_stage (
      .i_clk (clk),
      .i_rst (rst),
      .i_adv (w_adv),
      .i_a   (w_a),
      .i_b   (w_b),
      .i_ci  (w_carry[k]),
      .o_sum (w_s),
      .o_co  (w_carry[k+1])
    );
  end

  assign bus.valid_out = r_valid[STAGES-1];
  assign bus.sum       = w_sum;
  assign bus.co        = w_carry[STAGES];

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: four geometries (32/4, 8/3, 8/1, 5/4) share one driver
// and are checked against plain a+b+ci arithmetic at their expected latency.
`timescale 1ns/1ps
module tb_add_pipe;
  import add_pipe_pkg::*;

  localparam int ST = 4;
  localparam int N  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_valid;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic        drv_ci;
`ifdef ADD_PIPE_STALL_EN
  logic        drv_stall;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_pipe_if #(.DATAWIDTH(32)) bus_m  ();
  add_pipe_if #(.DATAWIDTH(8))  bus_w8 ();
  add_pipe_if #(.DATAWIDTH(8))  bus_s1 ();
  add_pipe_if #(.DATAWIDTH(5))  bus_w5 ();

  assign bus_m.valid_in  = drv_valid;
  assign bus_m.a         = drv_a;
  assign bus_m.b         = drv_b;
  assign bus_m.ci        = drv_ci;
  assign bus_w8.valid_in = drv_valid;
  assign bus_w8.a        = drv_a[7:0];
  assign bus_w8.b        = drv_b[7:0];
  assign bus_w8.ci       = drv_ci;
  assign bus_s1.valid_in = drv_valid;
  assign bus_s1.a        = drv_a[7:0];
  assign bus_s1.b        = drv_b[7:0];
  assign bus_s1.ci       = drv_ci;
  assign bus_w5.valid_in = drv_valid;
  assign bus_w5.a        = drv_a[4:0];
  assign bus_w5.b        = drv_b[4:0];
  assign bus_w5.ci       = drv_ci;
`ifdef ADD_PIPE_STALL_EN
  assign bus_m.stall  = drv_stall;
  assign bus_w8.stall = drv_stall;
  assign bus_s1.stall = drv_stall;
  assign bus_w5.stall = drv_stall;
`endif

  add_pipe #(.DATAWIDTH(32), .STAGES(4)) u_dut_m  (.clk(clk), .rst(rst), .bus(bus_m));
  add_pipe #(.DATAWIDTH(8),  .STAGES(3)) u_dut_w8 (.clk(clk), .rst(rst), .bus(bus_w8));
  add_pipe #(.DATAWIDTH(8),  .STAGES(1)) u_dut_s1 (.clk(clk), .rst(rst), .bus(bus_s1));
  add_pipe #(.DATAWIDTH(5),  .STAGES(4)) u_dut_w5 (.clk(clk), .rst(rst), .bus(bus_w5));

  // Reference: (a mod 2^w) + (b mod 2^w) + ci; bit w is the carry out.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input int w);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {32'b0, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    drv_valid = v;
    drv_a     = a;
    drv_b     = b;
    drv_ci    = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int j = 0; j < 10 + ST; j++) begin
      step();
      if (j == 10) rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_m.valid_out, bus_m.co, bus_m.sum} !== 34'h0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: valid=%b co=%b sum=%h, want 0/0/0", j, bus_m.valid_out, bus_m.co, bus_m.sum);
      end
      checks++;
      if ({bus_w8.valid_out, bus_s1.valid_out, bus_w5.valid_out} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle_small[%0d]: valids=%b%b%b, want 000", j, bus_w8.valid_out, bus_s1.valid_out, bus_w5.valid_out);
      end
    end
  endtask

  task automatic test_ripple();
    for (int j = 0; j <= ST + 1; j++) begin
      step();
      if (j == 0) drive(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
      else        drive(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (j == ST) begin
        if ({bus_m.valid_out, bus_m.co, bus_m.sum} !== {1'b1, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL ripple: valid=%b co=%b sum=%h, want 1/1/00000000", bus_m.valid_out, bus_m.co, bus_m.sum);
        end
      end else if (bus_m.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL ripple_valid[%0d]: valid=%b, want 0", j, bus_m.valid_out);
      end
    end
  endtask

  task automatic test_uneven();
    for (int j = 0; j <= 4; j++) begin
      step();
      if (j == 0) drive(1'b1, 32'hAA, 32'h56, 1'b0);
      else        drive(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (j == 3) begin
        if ({bus_w8.valid_out, bus_w8.co, bus_w8.sum} !== {1'b1, 1'b1, 8'h00}) begin
          errors++;
          $display("FAIL uneven_8x3: valid=%b co=%b sum=%h, want 1/1/00", bus_w8.valid_out, bus_w8.co, bus_w8.sum);
        end
      end else if (bus_w8.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL uneven_8x3_valid[%0d]: valid=%b, want 0", j, bus_w8.valid_out);
      end
      if (j == 4) begin
        checks++;
        if ({bus_w5.valid_out, bus_w5.co, bus_w5.sum} !== {1'b1, 1'b1, 5'h00}) begin
          errors++;
          $display("FAIL empty_chunk_5x4: valid=%b co=%b sum=%h, want 1/1/00", bus_w5.valid_out, bus_w5.co, bus_w5.sum);
        end
        checks++;
        if ({bus_m.valid_out, bus_m.co, bus_m.sum} !== {1'b1, 1'b0, 32'h100}) begin
          errors++;
          $display("FAIL uneven_main: valid=%b co=%b sum=%h, want 1/0/00000100", bus_m.valid_out, bus_m.co, bus_m.sum);
        end
      end
    end
    for (int j = 0; j <= 2; j++) begin
      step();
      if (j == 0) drive(1'b1, 32'h3, 32'h4, 1'b0);
      else        drive(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (j == 1) begin
        if ({bus_s1.valid_out, bus_s1.co, bus_s1.sum} !== {1'b1, 1'b0, 8'h07}) begin
          errors++;
          $display("FAIL single_stage: valid=%b co=%b sum=%h, want 1/0/07", bus_s1.valid_out, bus_s1.co, bus_s1.sum);
        end
      end else if (bus_s1.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL single_stage_valid[%0d]: valid=%b, want 0", j, bus_s1.valid_out);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] ah [N];
    logic [31:0] bh [N];
    logic        ch [N];
    logic [32:0] e;
    int          idx;
    for (int i = 0; i < N; i++) begin
      ah[i] = $urandom();
      bh[i] = $urandom();
      ch[i] = ($urandom_range(0, 1) != 0);
    end
    ah[0] = 32'hFFFF_FFFF; bh[0] = 32'h0;         ch[0] = 1'b1;
    ah[1] = 32'hFFFF_FFFF; bh[1] = 32'hFFFF_FFFF; ch[1] = 1'b1;
    ah[2] = 32'h0;         bh[2] = 32'h0;         ch[2] = 1'b0;
    for (int j = 0; j < N + ST + 1; j++) begin
      step();
      if (j < N) drive(1'b1, ah[j], bh[j], ch[j]);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      idx = j - ST;
      checks++;
      if (idx >= 0 && idx < N) begin
        e = ref_add(ah[idx], bh[idx], ch[idx], 32);
        if ({bus_m.valid_out, bus_m.co, bus_m.sum} !== {1'b1, e}) begin
          errors++;
          $display("FAIL stream_main[%0d]: valid=%b co=%b sum=%h, want 1/%b/%h", idx, bus_m.valid_out, bus_m.co, bus_m.sum, e[32], e[31:0]);
        end
      end else if (bus_m.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL stream_main_idle[%0d]: valid=%b, want 0", j, bus_m.valid_out);
      end
      idx = j - 3;
      checks++;
      if (idx >= 0 && idx < N) begin
        e = ref_add(ah[idx], bh[idx], ch[idx], 8);
        if ({bus_w8.valid_out, bus_w8.co, bus_w8.sum} !== {1'b1, e[8:0]}) begin
          errors++;
          $display("FAIL stream_8x3[%0d]: valid=%b co=%b sum=%h, want 1/%b/%h", idx, bus_w8.valid_out, bus_w8.co, bus_w8.sum, e[8], e[7:0]);
        end
      end else if (bus_w8.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL stream_8x3_idle[%0d]: valid=%b, want 0", j, bus_w8.valid_out);
      end
      idx = j - 1;
      checks++;
      if (idx >= 0 && idx < N) begin
        e = ref_add(ah[idx], bh[idx], ch[idx], 8);
        if ({bus_s1.valid_out, bus_s1.co, bus_s1.sum} !== {1'b1, e[8:0]}) begin
          errors++;
          $display("FAIL stream_8x1[%0d]: valid=%b co=%b sum=%h, want 1/%b/%h", idx, bus_s1.valid_out, bus_s1.co, bus_s1.sum, e[8], e[7:0]);
        end
      end else if (bus_s1.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL stream_8x1_idle[%0d]: valid=%b, want 0", j, bus_s1.valid_out);
      end
      idx = j - 4;
      checks++;
      if (idx >= 0 && idx < N) begin
        e = ref_add(ah[idx], bh[idx], ch[idx], 5);
        if ({bus_w5.valid_out, bus_w5.co, bus_w5.sum} !== {1'b1, e[5:0]}) begin
          errors++;
          $display("FAIL stream_5x4[%0d]: valid=%b co=%b sum=%h, want 1/%b/%h", idx, bus_w5.valid_out, bus_w5.co, bus_w5.sum, e[5], e[4:0]);
        end
      end else if (bus_w5.valid_out !== 1'b0) begin
        errors++;
        $display("FAIL stream_5x4_idle[%0d]: valid=%b, want 0", j, bus_w5.valid_out);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      pa[i] = $urandom();
      pb[i] = $urandom();
    end
    e = ref_add(pa[2], pb[2], 1'b1, 32);
    for (int j = 0; j <= ST + 3; j++) begin
      step();
      rst = (j == 1);
      if (j < 3) drive(1'b1, pa[j], pb[j], 1'b1);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      if (j == 2) begin
        checks++;
        if ({bus_m.valid_out, bus_m.co, bus_m.sum} !== 34'h0) begin
          errors++;
          $display("FAIL midreset_clear: valid=%b co=%b sum=%h, want 0/0/0", bus_m.valid_out, bus_m.co, bus_m.sum);
        end
      end else if (j == 2 + ST) begin
        checks++;
        if ({bus_m.valid_out, bus_m.co, bus_m.sum} !== {1'b1, e}) begin
          errors++;
          $display("FAIL midreset_new: valid=%b co=%b sum=%h, want 1/%b/%h", bus_m.valid_out, bus_m.co, bus_m.sum, e[32], e[31:0]);
        end
      end else if (j > 2) begin
        checks++;
        if (bus_m.valid_out !== 1'b0) begin
          errors++;
          $display("FAIL midreset_discard[%0d]: valid=%b, want 0", j, bus_m.valid_out);
        end
      end
      if (j >= 2) begin
        checks++;
        if (bus_w8.valid_out !== (j == 5)) begin
          errors++;
          $display("FAIL midreset_8x3[%0d]: valid=%b, want %b", j, bus_w8.valid_out, (j == 5));
        end
      end
    end
  endtask

`ifdef ADD_PIPE_STALL_EN
  task automatic test_stall();
    int          adv = 0;
    int          n = 0;
    int          seen = 0;
    int          s_at [3];
    logic [32:0] ev [3];
    logic        pv = 1'b0;
    logic        pst = 1'b0;
    logic [31:0] pa = 32'h0;
    logic        found;
    logic [32:0] e;
    logic [33:0] obs;
    logic [33:0] last_obs = 34'h0;
    for (int j = 0; j < 14; j++) begin
      step();
      if (!pst) begin
        adv++;
        if (pv) begin
          s_at[n] = adv;
          ev[n]   = ref_add(pa, pa, 1'b0, 32);
          n++;
        end
      end
      case (j)
        0:       begin drive(1'b1, 32'h1, 32'h1, 1'b0); drv_stall = 1'b0; end
        1:       begin drive(1'b1, 32'h2, 32'h2, 1'b0); drv_stall = 1'b0; end
        2, 3:    begin drive(1'b1, 32'h3, 32'h3, 1'b0); drv_stall = 1'b1; end
        4:       begin drive(1'b1, 32'h3, 32'h3, 1'b0); drv_stall = 1'b0; end
        default: begin drive(1'b0, 32'h0, 32'h0, 1'b0); drv_stall = 1'b0; end
      endcase
      @(negedge clk);
      obs = {bus_m.valid_out, bus_m.co, bus_m.sum};
      found = 1'b0;
      e = 33'h0;
      for (int k = 0; k < n; k++) begin
        if (s_at[k] + ST - 1 == adv) begin
          found = 1'b1;
          e = ev[k];
        end
      end
      checks++;
      if (found) begin
        if (obs !== {1'b1, e}) begin
          errors++;
          $display("FAIL stall_result[%0d]: valid=%b co=%b sum=%h, want 1/%b/%h", j, obs[33], obs[32], obs[31:0], e[32], e[31:0]);
        end
      end else if (obs[33] !== 1'b0) begin
        errors++;
        $display("FAIL stall_valid[%0d]: valid=%b, want 0", j, obs[33]);
      end
      if (pst) begin
        checks++;
        if (obs !== last_obs) begin
          errors++;
          $display("FAIL stall_frozen[%0d]: out=%h, want %h", j, obs, last_obs);
        end
      end
      if (obs[33] === 1'b1) seen++;
      last_obs = obs;
      pv  = drv_valid;
      pst = drv_stall;
      pa  = drv_a;
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL stall_count: results=%0d, want 3", seen);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef ADD_PIPE_STALL_EN
    drv_stall = 1'b0;
`endif
    test_reset();
    test_ripple();
    idle(6);
    test_uneven();
    idle(6);
    test_stream();
    idle(6);
    test_reset_midflight();
    idle(6);
`ifdef ADD_PIPE_STALL_EN
    test_stall();
    idle(6);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
